// File: rtl/sopc_base_cpu_cpu_debug_mem_ctrl.sv
// -----------------------------------------------------------------------------
// sopc_base_cpu_cpu_debug_mem_ctrl
//
// Purpose:
//   Bridges single-cycle JTAG debug command pulses into Avalon-style
//   read/write transactions on the CPU debug memory. It keeps an address
//   register (MonAReg) and a data register (MonDReg). MonDReg carries write
//   data towards memory and read data back to the debug-slave tck stage.
//
// Ports:
//   clk                      system clock, rising edge only
//   reset_n                  asynchronous active-low reset
//   jdo[37:0]                JTAG data word
//                              [37]              clear cmd_overrun (ocimem_a)
//                              [35]              read after address load (ocimem_a)
//                              [34:3]            write data (ocimem_b)
//                              [ADDR_W+25:26]    address (ocimem_a)
//   take_action_ocimem_a     pulse: load address, optionally read
//   take_no_action_ocimem_a  pulse: read at the current address
//   take_action_ocimem_b     pulse: write jdo data at the current address
//   mem_address/mem_read/mem_write/mem_writedata   request to memory
//   mem_waitrequest          memory stall; request completes when low
//   mem_readdata/mem_readdatavalid                 read return
//   MonDReg                  monitor data register
//   mem_busy                 high while a transaction is in flight
//   cmd_overrun              sticky: a command arrived while busy
//
// Configuration:
//   SOPC_BASE_CPU_DEBUG_MEM_AUTOINC_EN  when defined, MonAReg advances by one
//   after each completed read (data return) or write (acceptance). When it
//   is undefined, MonAReg only changes on take_action_ocimem_a.
// -----------------------------------------------------------------------------
module sopc_base_cpu_cpu_debug_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              mem_busy,
  output logic              cmd_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Address to use after a completed access.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur);
`ifdef SOPC_BASE_CPU_DEBUG_MEM_AUTOINC_EN
    return cur + ADDR_ONE;
`else
    return cur;
`endif
  endfunction

  state_t              state_q,       state_d;
  logic [ADDR_W-1:0]   mon_a_reg_q,   mon_a_reg_d;
  logic [31:0]         mon_d_reg_q,   mon_d_reg_d;
  logic                mem_read_q,    mem_read_d;
  logic                mem_write_q,   mem_write_d;
  logic                mem_busy_q,    mem_busy_d;
  logic                cmd_overrun_q, cmd_overrun_d;
  logic                any_cmd_s;

  // jdo bits that carry no meaning for this block.
  logic                unused_jdo_s;
  assign unused_jdo_s = ^{jdo[36], jdo[2:0]};

  assign any_cmd_s = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  // Next-state, register-update and output-decode logic.
  always_comb begin
    state_d       = state_q;
    mon_a_reg_d   = mon_a_reg_q;
    mon_d_reg_d   = mon_d_reg_q;
    cmd_overrun_d = cmd_overrun_q;

    case (state_q)
      ST_IDLE: begin
        // ocimem_b wins over ocimem_a, which wins over no_action. Losers are
        // dropped silently because the block was idle when they arrived.
        if (take_action_ocimem_b) begin
          mon_d_reg_d = jdo[34:3];
          state_d     = ST_WR_REQ;
        end else if (take_action_ocimem_a) begin
          mon_a_reg_d = jdo[ADDR_W+25:26];
          if (jdo[37]) begin
            cmd_overrun_d = 1'b0;
          end else begin
            cmd_overrun_d = cmd_overrun_q;
          end
          if (jdo[35]) begin
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        if (!mem_waitrequest) begin
          // Zero-latency data may return in the same cycle the read is accepted.
          if (mem_readdatavalid) begin
            mon_d_reg_d = mem_readdata;
            mon_a_reg_d = next_addr(mon_a_reg_q);
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else begin
          state_d = ST_RD_REQ;
        end
      end

      ST_RD_WAIT: begin
        if (mem_readdatavalid) begin
          mon_d_reg_d = mem_readdata;
          mon_a_reg_d = next_addr(mon_a_reg_q);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_WR_REQ: begin
        if (!mem_waitrequest) begin
          mon_a_reg_d = next_addr(mon_a_reg_q);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WR_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any command while a transaction is in flight is dropped and flagged.
    if ((state_q != ST_IDLE) && any_cmd_s) begin
      cmd_overrun_d = 1'b1;
    end else begin
      cmd_overrun_d = cmd_overrun_d;
    end

    // Request strobes come from the next state so they leave a flop and
    // appear the cycle after the command pulse; they are mutually exclusive.
    mem_read_d  = (state_d == ST_RD_REQ);
    mem_write_d = (state_d == ST_WR_REQ);
    mem_busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mon_a_reg_q   <= {ADDR_W{1'b0}};
      mon_d_reg_q   <= 32'h0000_0000;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_busy_q    <= 1'b0;
      cmd_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mon_a_reg_q   <= mon_a_reg_d;
      mon_d_reg_q   <= mon_d_reg_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_busy_q    <= mem_busy_d;
      cmd_overrun_q <= cmd_overrun_d;
    end
  end

  assign mem_address   = mon_a_reg_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_writedata = mon_d_reg_q;
  assign MonDReg       = mon_d_reg_q;
  assign mem_busy      = mem_busy_q;
  assign cmd_overrun   = cmd_overrun_q;

endmodule

// File: tb/tb_sopc_base_cpu_cpu_debug_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sopc_base_cpu_cpu_debug_mem_ctrl.
// The bench plays the JTAG side and the memory slave. A transaction-level
// model tracks the address register, data register and overrun flag.
// -----------------------------------------------------------------------------
module tb_sopc_base_cpu_cpu_debug_mem_ctrl;

  localparam int ADDR_W = 8;
`ifdef SOPC_BASE_CPU_DEBUG_MEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic [31:0]       MonDReg;
  logic              mem_busy;
  logic              cmd_overrun;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // reference model state
  logic [7:0]  exp_addr;
  logic [31:0] exp_mond;
  logic        exp_ovr;

  always #5 clk = ~clk;

  sopc_base_cpu_cpu_debug_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_waitrequest         (mem_waitrequest),
    .mem_readdata            (mem_readdata),
    .mem_readdatavalid       (mem_readdatavalid),
    .MonDReg                 (MonDReg),
    .mem_busy                (mem_busy),
    .cmd_overrun             (cmd_overrun)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  // Advance one cycle; all one-cycle drives return to their idle values.
  task automatic tick();
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    mem_readdatavalid       = 1'b0;
    mem_waitrequest         = 1'b1;
    mem_readdata            = $urandom;
    jdo                     = rand_jdo();
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, mem_busy, 1'b0);
    check_val({tag, "_rd"}, mem_read, 1'b0);
    check_val({tag, "_wr"}, mem_write, 1'b0);
    check_val({tag, "_addr"}, mem_address, exp_addr);
    check_val({tag, "_mond"}, MonDReg, exp_mond);
    check_val({tag, "_wdata"}, mem_writedata, exp_mond);
    check_val({tag, "_ovr"}, cmd_overrun, exp_ovr);
  endtask

  // Randomly fire a command while busy; it must be dropped and flagged.
  task automatic maybe_inject(input bit en);
    if (en && ($urandom_range(3, 0) == 0)) begin
      case ($urandom_range(2, 0))
        0:       take_action_ocimem_a    = 1'b1;
        1:       take_no_action_ocimem_a = 1'b1;
        default: take_action_ocimem_b    = 1'b1;
      endcase
      exp_ovr = 1'b1;
    end
  endtask

  // Memory-slave side of a read, starting the cycle after the command.
  task automatic serve_read(input int waits, input int lat, input bit inj, input logic [31:0] rdata);
    for (int i = 0; i < waits; i++) begin
      check_val("rd_req_rd", mem_read, 1'b1);
      check_val("rd_req_wr", mem_write, 1'b0);
      check_val("rd_req_addr", mem_address, exp_addr);
      check_val("rd_req_busy", mem_busy, 1'b1);
      maybe_inject(inj);
      tick();
    end
    check_val("rd_acc_rd", mem_read, 1'b1);
    check_val("rd_acc_addr", mem_address, exp_addr);
    mem_waitrequest = 1'b0;
    if (lat == 0) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = rdata;
    end
    tick();
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        check_val("rd_wait_rd", mem_read, 1'b0);
        check_val("rd_wait_busy", mem_busy, 1'b1);
        maybe_inject(inj);
        tick();
      end
      check_val("rd_wait_rd", mem_read, 1'b0);
      check_val("rd_wait_busy", mem_busy, 1'b1);
      mem_readdatavalid = 1'b1;
      mem_readdata      = rdata;
      tick();
    end
    exp_mond = rdata;
    if (AUTOINC) exp_addr = exp_addr + 8'd1;
    check_idle("rd_done");
  endtask

  task automatic serve_write(input int waits, input bit inj);
    for (int i = 0; i < waits; i++) begin
      check_val("wr_req_wr", mem_write, 1'b1);
      check_val("wr_req_rd", mem_read, 1'b0);
      check_val("wr_req_addr", mem_address, exp_addr);
      check_val("wr_req_data", mem_writedata, exp_mond);
      maybe_inject(inj);
      tick();
    end
    check_val("wr_acc_wr", mem_write, 1'b1);
    check_val("wr_acc_data", mem_writedata, exp_mond);
    check_val("wr_acc_addr", mem_address, exp_addr);
    mem_waitrequest = 1'b0;
    tick();
    if (AUTOINC) exp_addr = exp_addr + 8'd1;
    check_idle("wr_done");
  endtask

  task automatic cmd_a(input logic [7:0] addr, input bit rd, input bit clr, input bit extra_na);
    jdo[33:26] = addr;
    jdo[35]    = rd;
    jdo[37]    = clr;
    take_action_ocimem_a    = 1'b1;
    take_no_action_ocimem_a = extra_na;
    tick();
    exp_addr = addr;
    if (clr) exp_ovr = 1'b0;
  endtask

  task automatic cmd_b(input logic [31:0] data, input bit extra);
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    if (extra) begin
      take_action_ocimem_a    = 1'b1;
      take_no_action_ocimem_a = 1'b1;
    end
    tick();
    exp_mond = data;
  endtask

  task automatic cmd_na();
    take_no_action_ocimem_a = 1'b1;
    tick();
  endtask

  initial begin
    reset_n                 = 1'b0;
    jdo                     = 38'd0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    mem_waitrequest         = 1'b1;
    mem_readdata            = 32'd0;
    mem_readdatavalid       = 1'b0;
    exp_addr = 8'd0;
    exp_mond = 32'd0;
    exp_ovr  = 1'b0;

    // reset then idle
    repeat (3) tick();
    check_idle("reset");
    reset_n = 1'b1;
    repeat (2) tick();
    check_idle("post_reset");

    // read at 0x10, two stall cycles, data one cycle after acceptance
    cmd_a(8'h10, 1'b1, 1'b0, 1'b0);
    serve_read(2, 1, 1'b0, 32'hDEAD_BEEF);
    check_val("req037_mond", MonDReg, 32'hDEAD_BEEF);

    // write at 0x10, then a plain read shows where the address went
    cmd_a(8'h10, 1'b0, 1'b0, 1'b0);
    check_idle("load10");
    cmd_b(32'h1234_5678, 1'b0);
    check_val("req038_wdata", mem_writedata, 32'h1234_5678);
    check_val("req038_waddr", mem_address, 8'h10);
    serve_write(1, 1'b0);
    cmd_na();
    check_val("req038_raddr", mem_address, AUTOINC ? 8'h11 : 8'h10);
    serve_read(0, 2, 1'b0, $urandom);

    // address wrap after a write at the top address
    cmd_a(8'hFF, 1'b0, 1'b0, 1'b0);
    cmd_b($urandom, 1'b0);
    serve_write(0, 1'b0);
    check_val("req039_addr", mem_address, AUTOINC ? 8'h00 : 8'hFF);

    // zero-latency read return
    cmd_na();
    serve_read(1, 0, 1'b0, $urandom);

    // command during RD_WAIT is dropped and flags overrun; clear afterwards
    cmd_na();
    mem_waitrequest = 1'b0;
    tick();
    take_no_action_ocimem_a = 1'b1;
    exp_ovr = 1'b1;
    tick();
    check_val("req040_ovr", cmd_overrun, 1'b1);
    check_val("req040_busy", mem_busy, 1'b1);
    check_val("req040_rd", mem_read, 1'b0);
    mem_readdatavalid = 1'b1;
    mem_readdata      = 32'hA5A5_0F0F;
    tick();
    exp_mond = 32'hA5A5_0F0F;
    if (AUTOINC) exp_addr = exp_addr + 8'd1;
    check_idle("req040_done");
    cmd_a(8'h22, 1'b0, 1'b1, 1'b0);
    check_val("req040_clr", cmd_overrun, 1'b0);
    check_idle("req040_clr");

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(4, 0);
      case (op)
        0: begin
          cmd_a(8'($urandom), 1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
          serve_read($urandom_range(3, 0), $urandom_range(3, 0), 1'b1, $urandom);
        end
        1: begin
          cmd_a(8'($urandom), 1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
          check_idle("rnd_load");
        end
        2: begin
          cmd_na();
          serve_read($urandom_range(3, 0), $urandom_range(3, 0), 1'b1, $urandom);
        end
        default: begin
          cmd_b($urandom, 1'($urandom_range(1, 0)));
          serve_write($urandom_range(3, 0), 1'b1);
        end
      endcase
      // stray read data while idle must be ignored
      if ($urandom_range(2, 0) == 0) begin
        mem_readdatavalid = 1'b1;
        tick();
        check_idle("rnd_stray");
      end
    end

    // reset during a stalled write drops the request immediately
    cmd_b(32'hCAFE_F00D, 1'b0);
    check_val("req041_wr_before", mem_write, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("req041_wr_async", mem_write, 1'b0);
    check_val("req041_busy_async", mem_busy, 1'b0);
    tick();
    reset_n  = 1'b1;
    exp_addr = 8'd0;
    exp_mond = 32'd0;
    exp_ovr  = 1'b0;
    mem_readdatavalid = 1'b1;
    tick();
    check_idle("req041_after");
    cmd_na();
    serve_read(1, 1, 1'b0, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/sopc_base_cpu_cpu_debug_mem_ctrl.md
SOPC_BASE_CPU_CPU_DEBUG_MEM_CTRL -- requirements
Module: sopc_base_cpu_cpu_debug_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 8, word-address width of the debug memory port.
REQ-002 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port jdo  in  38  JTAG data word from the debug-slave sysclk stage.
REQ-005 SHALL have port take_action_ocimem_a  in  1  single-cycle pulse: address load, optional read.
REQ-006 SHALL have port take_no_action_ocimem_a  in  1  single-cycle pulse: read at current address.
REQ-007 SHALL have port take_action_ocimem_b  in  1  single-cycle pulse: write jdo data at current address.
REQ-008 SHALL have port mem_address  out  ADDR_W  word address to the debug memory.
REQ-009 SHALL have port mem_read  out  1  read request.
REQ-010 SHALL have port mem_write  out  1  write request.
REQ-011 SHALL have port mem_writedata  out  32  write data.
REQ-012 SHALL have port mem_waitrequest  in  1  memory stall; a request completes on the cycle it is sampled low.
REQ-013 SHALL have port mem_readdata  in  32  read data, valid with mem_readdatavalid.
REQ-014 SHALL have port mem_readdatavalid  in  1  read data strobe; exactly one per accepted read.
REQ-015 SHALL have port MonDReg  out  32  monitor data register returned to the debug-slave tck stage.
REQ-016 SHALL have port mem_busy  out  1  high whenever state is not IDLE.
REQ-017 SHALL have port cmd_overrun  out  1  sticky flag: a command arrived while busy.

Function
REQ-018 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-019 take_action_ocimem_a in IDLE: MonAReg <= jdo[ADDR_W+25:26]; if jdo[35]=1 go RD_REQ, else stay IDLE.
REQ-020 take_no_action_ocimem_a in IDLE: go RD_REQ at current MonAReg.
REQ-021 take_action_ocimem_b in IDLE: MonDReg <= jdo[34:3]; go WR_REQ.
REQ-022 Priority when several pulses coincide: ocimem_b > ocimem_a > no_action_ocimem_a; lower ones are dropped without setting cmd_overrun.
REQ-023 RD_REQ: mem_read=1, mem_address=MonAReg; when mem_waitrequest=0 go RD_WAIT.
REQ-024 RD_WAIT: mem_read=0; on mem_readdatavalid=1, MonDReg <= mem_readdata and go IDLE.
REQ-025 mem_readdatavalid in the same cycle as read acceptance SHALL be honoured: MonDReg loads and state goes IDLE directly.
REQ-026 WR_REQ: mem_write=1, mem_writedata=MonDReg, mem_address=MonAReg; when mem_waitrequest=0 go IDLE.
REQ-027 mem_read and mem_write SHALL never be high together and SHALL be registered outputs.
REQ-028 Any command pulse while not IDLE SHALL be ignored and SHALL set cmd_overrun.
REQ-029 cmd_overrun SHALL clear only on take_action_ocimem_a with jdo[37]=1 accepted in IDLE.
REQ-030 MonAReg wraps from 2^ADDR_W-1 to 0.
REQ-031 Idle-state latency: command pulse cycle N -> request asserted cycle N+1.

Reset
REQ-032 On reset_n low: state IDLE, MonAReg 0, MonDReg 0, mem_read 0, mem_write 0, mem_busy 0, cmd_overrun 0.
REQ-033 Reset mid-transaction SHALL abandon the access immediately; a late mem_readdatavalid after reset release in IDLE SHALL be ignored.

Configuration
REQ-034 Macro SOPC_BASE_CPU_DEBUG_MEM_AUTOINC_EN defined: MonAReg increments by 1 on each completed read (data return) or write (acceptance).
REQ-035 Macro undefined: MonAReg changes only on take_action_ocimem_a.

Verification
REQ-036 Reset then idle: all outputs 0, MonAReg 0.
REQ-037 ocimem_a, jdo[35]=1, addr 0x10, waitrequest 2 cycles, rdata 0xDEADBEEF after 1 cycle -> one read at 0x10, MonDReg=0xDEADBEEF, mem_busy low after.
REQ-038 ocimem_b, jdo[34:3]=0x12345678 at addr 0x10 -> single write 0x12345678 at 0x10; with AUTOINC_EN next read goes to 0x11, without it to 0x10.
REQ-039 AUTOINC_EN, addr 0xFF, write -> next access uses address 0x00.
REQ-040 no_action_ocimem_a pulse during RD_WAIT -> ignored, cmd_overrun=1; ocimem_a with jdo[37]=1 in IDLE clears it.
REQ-041 reset_n low during WR_REQ with waitrequest held -> mem_write drops asynchronously, state IDLE.
